// File: rtl/bike_reg_bank_loader.sv
// Command-driven sequencer that owns every write into the BIKE register-bank array:
// streams 32-bit words into a selected bank, clears banks, and tracks which banks are complete.
module bike_reg_bank_loader #(
    parameter int NUM_OF_BANKS = 4,
    parameter int BANK_SIZE    = 8,
    parameter int BANK_IDX_W   = (NUM_OF_BANKS > 1) ? $clog2(NUM_OF_BANKS) : 1
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   cmd_valid,
    output logic                                   cmd_ready,
    input  logic                                   cmd_op,
    input  logic [BANK_IDX_W-1:0]                  cmd_bank,
    input  logic [31:0]                            s_data,
    input  logic                                   s_valid,
    output logic                                   s_ready,
    output logic [NUM_OF_BANKS-1:0]                bank_resetn,
    output logic [NUM_OF_BANKS-1:0][BANK_SIZE-1:0] bank_enable,
    output logic [NUM_OF_BANKS-1:0][31:0]          bank_din,
    output logic [NUM_OF_BANKS-1:0]                bank_loaded,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   error
);
    localparam int                    CNT_W       = (BANK_SIZE > 1) ? $clog2(BANK_SIZE) : 1;
    localparam logic [BANK_IDX_W:0]   NUM_BANKS_L = (BANK_IDX_W + 1)'(NUM_OF_BANKS);
    localparam logic [CNT_W-1:0]      LAST_WORD   = CNT_W'(BANK_SIZE - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, LOAD, DONE} state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [BANK_IDX_W-1:0]   bank_q;
    logic [NUM_OF_BANKS-1:0] loaded_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    error_q;

    logic                    cmd_hs;
    logic                    bank_bad;
    logic                    word_hs;
    logic                    last_word;
    logic [NUM_OF_BANKS-1:0] cmd_sel;
    logic [NUM_OF_BANKS-1:0] bank_sel;

    always_comb begin
        cmd_sel  = '0;
        bank_sel = '0;
        for (int i = 0; i < NUM_OF_BANKS; i++) begin
            cmd_sel[i]  = (cmd_bank == BANK_IDX_W'(i));
            bank_sel[i] = (bank_q == BANK_IDX_W'(i));
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign s_ready   = (state_q == LOAD);
    assign cmd_hs    = cmd_valid & cmd_ready;
    assign bank_bad  = ({1'b0, cmd_bank} >= NUM_BANKS_L);
    assign word_hs   = s_valid & s_ready;
    assign last_word = word_hs & (cnt_q == LAST_WORD);

    // Zero-latency write: the enable goes out in the same cycle as the stream handshake.
    always_comb begin
        bank_enable = '0;
        for (int i = 0; i < NUM_OF_BANKS; i++) begin
            if (word_hs && bank_sel[i]) begin
                bank_enable[i] = BANK_SIZE'(1) << cnt_q;
            end
        end
    end

    assign bank_din = {NUM_OF_BANKS{s_data}};

    // Banks clear together with the controller while reset is held.
    assign bank_resetn = reset ? '0 : ((state_q == CLEAR) ? ~bank_sel : '1);

    assign bank_loaded = loaded_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bank_q   <= '0;
            loaded_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_hs) begin
                        if (bank_bad) begin
                            error_q <= 1'b1;
                        end else begin
                            bank_q <= cmd_bank;
                            busy_q <= 1'b1;
                            if (cmd_op) begin
                                state_q <= CLEAR;
                            end else begin
                                state_q  <= LOAD;
                                cnt_q    <= '0;
                                // A bank being rewritten must never look complete.
                                loaded_q <= loaded_q & ~cmd_sel;
                            end
                        end
                    end
                end
                CLEAR: begin
                    loaded_q <= loaded_q & ~bank_sel;
                    done_q   <= 1'b1;
                    state_q  <= DONE;
                end
                LOAD: begin
                    if (last_word) begin
                        cnt_q    <= '0;
                        loaded_q <= loaded_q | bank_sel;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end else if (word_hs) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bike_reg_bank_loader.sv
// Scoreboard bench for bike_reg_bank_loader: stimulus pushes expected bank events,
// a negedge monitor pops and compares them as the DUT produces writes, clears, done and error pulses.
module tb_bike_reg_bank_loader;
    localparam int NB = 4;
    localparam int BS = 8;
    localparam int IW = 3;

    localparam int EV_WR = 0;
    localparam int EV_DN = 1;
    localparam int EV_ER = 2;
    localparam int EV_CL = 3;

    typedef struct {
        int          kind;
        int          bank;
        int          idx;
        logic [31:0] data;
        logic [3:0]  val;
        int          lat;
    } ev_t;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    cmd_valid = 1'b0;
    logic                    cmd_ready;
    logic                    cmd_op = 1'b0;
    logic [IW-1:0]           cmd_bank = '0;
    logic [31:0]             s_data = '0;
    logic                    s_valid = 1'b0;
    logic                    s_ready;
    logic [NB-1:0]           bank_resetn;
    logic [NB-1:0][BS-1:0]   bank_enable;
    logic [NB-1:0][31:0]     bank_din;
    logic [NB-1:0]           bank_loaded;
    logic                    busy;
    logic                    done;
    logic                    error;

    int       checks = 0;
    int       errors = 0;
    int       cyc = 0;
    int       acc = 0;
    ev_t      q[$];
    logic [3:0] model = '0;

    bike_reg_bank_loader #(
        .NUM_OF_BANKS(NB),
        .BANK_SIZE   (BS),
        .BANK_IDX_W  (IW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_bank   (cmd_bank),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .bank_resetn(bank_resetn),
        .bank_enable(bank_enable),
        .bank_din   (bank_din),
        .bank_loaded(bank_loaded),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push(input int kind, input int bank, input int idx,
                                 input logic [31:0] data, input logic [3:0] val, input int lat);
        ev_t e;
        e.kind = kind; e.bank = bank; e.idx = idx; e.data = data; e.val = val; e.lat = lat;
        q.push_back(e);
    endfunction

    task automatic take(input int kind, output ev_t e, output bit ok);
        chk("event_expected", {31'd0, q.size() != 0}, 32'd1);
        ok = (q.size() != 0);
        if (ok) begin
            e = q.pop_front();
            chk("event_kind", e.kind, kind);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        ev_t e;
        bit  ok;
        int  wb;
        int  wk;
        cyc++;
        if (!reset) begin
            chk("enable_onehot", {31'd0, $countones(bank_enable) <= 1}, 32'd1);
            chk("ready_exclusive", {31'd0, cmd_ready & s_ready}, 32'd0);
            if (bank_enable != '0) begin
                wb = 0; wk = 0;
                for (int i = 0; i < NB; i++)
                    for (int k = 0; k < BS; k++)
                        if (bank_enable[i][k]) begin wb = i; wk = k; end
                chk("enable_only_in_load", {31'd0, s_ready}, 32'd1);
                take(EV_WR, e, ok);
                if (ok) begin
                    chk("wr_bank", wb, e.bank);
                    chk("wr_word", wk, e.idx);
                    chk("wr_data", bank_din[wb], e.data);
                end
            end
            if (bank_resetn != '1) begin
                take(EV_CL, e, ok);
                if (ok) chk("clr_resetn", {28'd0, bank_resetn}, {28'd0, e.val});
            end
            if (done) begin
                take(EV_DN, e, ok);
                if (ok) begin
                    chk("done_loaded", {28'd0, bank_loaded}, {28'd0, e.val});
                    chk("done_latency", cyc - acc, e.lat);
                end
            end
            if (error) begin
                take(EV_ER, e, ok);
                if (ok) begin
                    chk("err_latency", cyc - acc, e.lat);
                    chk("err_no_enable", bank_enable, '0);
                    chk("err_no_clear", {28'd0, bank_resetn}, 32'hF);
                end
            end
            if (cmd_valid && cmd_ready) acc = cyc;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cmd(input bit op, input int bank);
        bit got = 1'b0;
        cmd_op    = op;
        cmd_bank  = IW'(bank);
        cmd_valid = 1'b1;
        for (int t = 0; t < 30 && !got; t++) begin
            if (cmd_ready) got = 1'b1;
            step();
        end
        cmd_valid = 1'b0;
        if (!got) chk("cmd_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_load(input int bank, input logic [31:0] w[BS], input int st[BS]);
        int lat = 9;
        for (int k = 0; k < BS; k++) begin
            lat += st[k];
            push(EV_WR, bank, k, w[k], 4'h0, 0);
        end
        model = model | (4'b1 << bank);
        push(EV_DN, bank, 0, 32'h0, model, lat);
        do_cmd(1'b0, bank);
        chk("load_cmd_ready_low", {31'd0, cmd_ready}, 32'd0);
        for (int k = 0; k < BS; k++) begin
            s_valid = 1'b0;
            repeat (st[k]) step();
            s_valid = 1'b1;
            s_data  = w[k];
            step();
        end
        s_valid = 1'b0;
    endtask

    task automatic do_clear(input int bank);
        push(EV_CL, bank, 0, 32'h0, ~(4'b1 << bank), 0);
        model = model & ~(4'b1 << bank);
        push(EV_DN, bank, 0, 32'h0, model, 2);
        do_cmd(1'b1, bank);
    endtask

    task automatic do_bad(input int bank);
        push(EV_ER, bank, 0, 32'h0, 4'h0, 1);
        do_cmd(1'b0, bank);
        chk("bad_stays_idle", {31'd0, cmd_ready}, 32'd1);
        chk("bad_not_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [31:0] w[BS];
        int          st[BS];
        int          bank;
        bit          op;

        // Reset state
        step(); step();
        chk("rst_resetn_low", {28'd0, bank_resetn}, 32'h0);
        chk("rst_loaded", {28'd0, bank_loaded}, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        #1;
        chk("idle_resetn_high", {28'd0, bank_resetn}, 32'hF);
        chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("idle_s_ready", {31'd0, s_ready}, 32'd0);
        chk("idle_enable", bank_enable, 32'h0);
        chk("idle_done_err", {30'd0, done, error}, 32'd0);

        // Case 1: LOAD bank 2, words 1..8, no stalls
        for (int k = 0; k < BS; k++) begin w[k] = 32'(k + 1); st[k] = 0; end
        do_load(2, w, st);

        // Case 2: LOAD bank 0 with a 5-cycle stall between words 3 and 4
        for (int k = 0; k < BS; k++) begin w[k] = 32'hA000_0000 + 32'(k); st[k] = 0; end
        st[4] = 5;
        do_load(0, w, st);

        // Case 3: load bank 1 then clear it
        for (int k = 0; k < BS; k++) begin w[k] = 32'h1111_0000 | 32'(k * 3); st[k] = 0; end
        do_load(1, w, st);
        do_clear(1);

        // Case 4: out-of-range bank
        do_bad(4);
        do_bad(7);

        // Case 5: reset after 3 of 8 words of a LOAD to bank 3
        for (int k = 0; k < 3; k++) push(EV_WR, 3, k, 32'hBEEF_0000 + 32'(k), 4'h0, 0);
        do_cmd(1'b0, 3);
        for (int k = 0; k < 3; k++) begin
            s_valid = 1'b1;
            s_data  = 32'hBEEF_0000 + 32'(k);
            step();
        end
        s_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_resetn", {28'd0, bank_resetn}, 32'h0);
        chk("midrst_loaded", {28'd0, bank_loaded}, 32'h0);
        chk("midrst_no_pending", q.size(), 32'd0);
        q.delete();
        model = '0;
        step();
        reset = 1'b0;
        for (int k = 0; k < BS; k++) begin w[k] = 32'hC0DE_0000 + 32'(k); st[k] = 0; end
        do_load(3, w, st);

        // Case 6: mixed random traffic against the scoreboard model
        for (int it = 0; it < 150; it++) begin
            repeat ($urandom_range(0, 2)) begin
                s_valid = 1'($urandom_range(0, 1));
                s_data  = $urandom;
                step();
            end
            s_valid = 1'b0;
            bank = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3));
            op   = 1'($urandom_range(0, 2) == 0);
            if (bank >= NB) begin
                do_bad(bank);
            end else if (op) begin
                do_clear(bank);
            end else begin
                for (int k = 0; k < BS; k++) begin
                    w[k]  = $urandom;
                    st[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
                end
                do_load(bank, w, st);
            end
        end

        for (int t = 0; t < 50 && q.size() != 0; t++) step();
        step(); step();
        chk("queue_drained", q.size(), 32'd0);
        chk("final_loaded", {28'd0, bank_loaded}, {28'd0, model});
        chk("final_idle", {31'd0, cmd_ready}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
